// File: rtl/vga_scan_controller.sv
// Raster sequencer for external VGA up/down counters: issues count/load strobes
// at pixel rate, decodes registered sync/active, parks at frame end on request.
module vga_scan_controller #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_TOTAL  = 800,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_TOTAL  = 525
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pix_en,
    input  logic [15:0] hcount,
    input  logic [15:0] vcount,
    input  logic        run,
    output logic        h_up,
    output logic        h_ld,
    output logic        v_up,
    output logic        v_ld,
    output logic        hsync,
    output logic        vsync,
    output logic        active,
    output logic        frame_tick,
    output logic        parked,
    output logic        resync
);

    // state | meaning
    // INIT  | one-clk load of both counters to 0
    // RUN   | scanning, strobes at pix_en
    // PARK  | held at frame boundary until run returns
    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_RUN  = 2'd1,
        ST_PARK = 2'd2
    } state_t;

    localparam logic [15:0] H_TOT  = 16'(H_TOTAL);
    localparam logic [15:0] V_TOT  = 16'(V_TOTAL);
    localparam logic [15:0] H_LAST = 16'(H_TOTAL - 1);
    localparam logic [15:0] V_LAST = 16'(V_TOTAL - 1);
    localparam logic [15:0] H_ACT  = 16'(H_ACTIVE);
    localparam logic [15:0] V_ACT  = 16'(V_ACTIVE);
    localparam logic [15:0] HS_BEG = 16'(H_ACTIVE + H_FP);
    localparam logic [15:0] HS_END = 16'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [15:0] VS_BEG = 16'(V_ACTIVE + V_FP);
    localparam logic [15:0] VS_END = 16'(V_ACTIVE + V_FP + V_SYNC - 1);

    state_t state_q, state_d;
    logic   hsync_q, hsync_d;
    logic   vsync_q, vsync_d;
    logic   active_q, active_d;
    logic   tick_q, tick_d;
    logic   resync_q, resync_d;

    logic   out_of_range;
    logic   h_end;
    logic   v_end;

    assign out_of_range = (hcount >= H_TOT) || (vcount >= V_TOT);
    assign h_end        = (hcount == H_LAST);
    assign v_end        = (vcount == V_LAST);

    always_comb begin
        state_d  = state_q;
        h_up     = 1'b0;
        h_ld     = 1'b0;
        v_up     = 1'b0;
        v_ld     = 1'b0;
        tick_d   = 1'b0;
        resync_d = 1'b0;
        // Strobes must stay low while reset is held, even though the counters see them live.
        if (!reset) begin
            unique case (state_q)
                ST_INIT: begin
                    h_ld    = 1'b1;
                    v_ld    = 1'b1;
                    state_d = ST_RUN;
                end
                ST_RUN: begin
                    if (out_of_range) begin
                        resync_d = 1'b1;
                        state_d  = ST_INIT;
                    end else if (pix_en) begin
                        if (!h_end) begin
                            h_up = 1'b1;
                        end else if (!v_end) begin
                            h_ld = 1'b1;
                            v_up = 1'b1;
                        end else begin
                            h_ld   = 1'b1;
                            v_ld   = 1'b1;
                            tick_d = 1'b1;
                            if (!run) begin
                                state_d = ST_PARK;
                            end
                        end
                    end
                end
                ST_PARK: begin
                    if (run) begin
                        state_d = ST_RUN;
                    end
                end
                default: state_d = ST_INIT;
            endcase
        end
    end

    always_comb begin
        hsync_d  = 1'b1;
        vsync_d  = 1'b1;
        active_d = 1'b0;
        if (state_q == ST_RUN) begin
            hsync_d  = !((hcount >= HS_BEG) && (hcount <= HS_END));
            vsync_d  = !((vcount >= VS_BEG) && (vcount <= VS_END));
            active_d = (hcount < H_ACT) && (vcount < V_ACT);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_INIT;
            hsync_q  <= 1'b1;
            vsync_q  <= 1'b1;
            active_q <= 1'b0;
            tick_q   <= 1'b0;
            resync_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            hsync_q  <= hsync_d;
            vsync_q  <= vsync_d;
            active_q <= active_d;
            tick_q   <= tick_d;
            resync_q <= resync_d;
        end
    end

    assign hsync      = hsync_q;
    assign vsync      = vsync_q;
    assign active     = active_q;
    assign frame_tick = tick_q;
    assign resync     = resync_q;
    assign parked     = (state_q == ST_PARK);

endmodule

// File: tb/tb_vga_scan_controller.sv
// Bench for vga_scan_controller with a reduced raster (20x12) and a behavioural
// model of the external counters and the 1-in-4 pixel enable.
module tb_vga_scan_controller;

    localparam int HA = 10;
    localparam int HF = 2;
    localparam int HS = 3;
    localparam int HT = 20;
    localparam int VA = 6;
    localparam int VF = 2;
    localparam int VS = 2;
    localparam int VT = 12;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        pix_en = 1'b0;
    logic        run = 1'b1;
    logic [15:0] hcount = 16'd0;
    logic [15:0] vcount = 16'd0;
    logic        h_up, h_ld, v_up, v_ld;
    logic        hsync, vsync, active, frame_tick, parked, resync;

    int checks = 0;
    int failures = 0;

    logic        frc_req = 1'b0;
    logic [15:0] frc_h = 16'd0;
    logic [15:0] frc_v = 16'd0;
    logic [1:0]  div = 2'd0;

    vga_scan_controller #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_TOTAL(HT),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_TOTAL(VT)
    ) dut (
        .clk(clk), .reset(reset), .pix_en(pix_en),
        .hcount(hcount), .vcount(vcount), .run(run),
        .h_up(h_up), .h_ld(h_ld), .v_up(v_up), .v_ld(v_ld),
        .hsync(hsync), .vsync(vsync), .active(active),
        .frame_tick(frame_tick), .parked(parked), .resync(resync)
    );

    always #5 clk = ~clk;

    // External counters (D tied to 0) plus the pixel enable divider.
    always @(posedge clk) begin
        div    <= div + 2'd1;
        pix_en <= (div == 2'd3);
        if (frc_req) begin
            hcount <= frc_h;
            vcount <= frc_v;
        end else begin
            if (h_ld)      hcount <= 16'd0;
            else if (h_up) hcount <= hcount + 16'd1;
            if (v_ld)      vcount <= 16'd0;
            else if (v_up) vcount <= vcount + 16'd1;
        end
    end

    function automatic logic [2:0] exp_decode(input int h, input int v);
        logic hs, vs, act;
        hs  = !((h >= HA + HF) && (h <= HA + HF + HS - 1));
        vs  = !((v >= VA + VF) && (v <= VA + VF + VS - 1));
        act = (h < HA) && (v < VA);
        return {hs, vs, act};
    endfunction

    task automatic force_counts(input logic [15:0] h, input logic [15:0] v);
        @(negedge clk);
        frc_h = h;
        frc_v = v;
        frc_req = 1'b1;
        @(negedge clk);
        frc_req = 1'b0;
    endtask

    task automatic wait_pix(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 8; n++) begin
            if (pix_en) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        logic [9:0] obs;
        reset = 1'b1;
        force_counts(16'd300, 16'd100);
        @(negedge clk);
        obs = {h_up, h_ld, v_up, v_ld, hsync, vsync, active, frame_tick, parked, resync};
        checks++;
        if (obs !== 10'b0000110000) begin
            failures++;
            $display("FAIL reset_outputs got=%b want=%b", obs, 10'b0000110000);
        end
        reset = 1'b0;
        #1;
        checks++;
        if ({h_up, h_ld, v_up, v_ld} !== 4'b0101) begin
            failures++;
            $display("FAIL init_strobes got=%b want=0101", {h_up, h_ld, v_up, v_ld});
        end
        @(negedge clk);
        checks++;
        if (hcount !== 16'd0 || vcount !== 16'd0) begin
            failures++;
            $display("FAIL init_counts got=%0d/%0d want=0/0", hcount, vcount);
        end
        checks++;
        if ({hsync, vsync, active} !== 3'b110) begin
            failures++;
            $display("FAIL init_decode got=%b want=110", {hsync, vsync, active});
        end
        @(negedge clk);
        checks++;
        if (active !== 1'b1) begin
            failures++;
            $display("FAIL first_run_active got=%b want=1", active);
        end
    endtask

    task automatic test_frame();
        logic [2:0]  sbq[$];
        logic [2:0]  e;
        logic [2:0]  obs;
        bit          found;
        bit          prev_pix;
        logic        prev_hs, prev_vs;
        logic [15:0] prev_h, prev_v;
        logic [15:0] hs_fall_h, vs_fall_v;
        int          clk_n, pix_n, hs_n, vs_n, act_n, sb_fail;
        found = 1'b0;
        for (int n = 0; n < 2000; n++) begin
            @(negedge clk);
            if (frame_tick) begin
                found = 1'b1;
                break;
            end
        end
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL frame_first_tick got=none want=tick within 2000 clk");
            return;
        end
        sbq.push_back(exp_decode(int'(hcount), int'(vcount)));
        prev_pix = pix_en; prev_h = hcount; prev_v = vcount;
        prev_hs = hsync; prev_vs = vsync;
        hs_fall_h = 16'hffff; vs_fall_v = 16'hffff;
        clk_n = 0; pix_n = 0; hs_n = 0; vs_n = 0; act_n = 0; sb_fail = 0;
        found = 1'b0;
        for (int n = 0; n < 2000; n++) begin
            @(negedge clk);
            clk_n++;
            e = sbq.pop_front();
            obs = {hsync, vsync, active};
            checks++;
            if (obs !== e) begin
                failures++;
                if (sb_fail < 5)
                    $display("FAIL decode_sb h=%0d v=%0d got=%b want=%b", prev_h, prev_v, obs, e);
                sb_fail++;
            end
            if (prev_pix) begin
                pix_n++;
                if (!hsync) hs_n++;
                if (!vsync) vs_n++;
                if (active) act_n++;
            end
            if (prev_hs && !hsync && hs_fall_h == 16'hffff) hs_fall_h = prev_h;
            if (prev_vs && !vsync && vs_fall_v == 16'hffff) vs_fall_v = prev_v;
            prev_pix = pix_en; prev_h = hcount; prev_v = vcount;
            prev_hs = hsync; prev_vs = vsync;
            if (frame_tick) begin
                found = 1'b1;
                break;
            end
            sbq.push_back(exp_decode(int'(hcount), int'(vcount)));
        end
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL frame_second_tick got=none want=tick within 2000 clk");
        end
        checks++;
        if (clk_n != HT * VT * 4) begin
            failures++;
            $display("FAIL frame_period got=%0d want=%0d", clk_n, HT * VT * 4);
        end
        checks++;
        if (pix_n != HT * VT) begin
            failures++;
            $display("FAIL frame_pixels got=%0d want=%0d", pix_n, HT * VT);
        end
        checks++;
        if (hs_n != HS * VT) begin
            failures++;
            $display("FAIL hsync_low_pixels got=%0d want=%0d", hs_n, HS * VT);
        end
        checks++;
        if (vs_n != VS * HT) begin
            failures++;
            $display("FAIL vsync_low_pixels got=%0d want=%0d", vs_n, VS * HT);
        end
        checks++;
        if (act_n != HA * VA) begin
            failures++;
            $display("FAIL active_pixels got=%0d want=%0d", act_n, HA * VA);
        end
        checks++;
        if (hs_fall_h != 16'(HA + HF)) begin
            failures++;
            $display("FAIL hsync_start got=%0d want=%0d", hs_fall_h, HA + HF);
        end
        checks++;
        if (vs_fall_v != 16'(VA + VF)) begin
            failures++;
            $display("FAIL vsync_start got=%0d want=%0d", vs_fall_v, VA + VF);
        end
    endtask

    task automatic test_line_wrap();
        bit ok;
        force_counts(16'(HT - 1), 16'(VT - 3));
        wait_pix(ok);
        checks++;
        if (!ok || {h_up, h_ld, v_up, v_ld} !== 4'b0110) begin
            failures++;
            $display("FAIL line_wrap_strobes got=%b want=0110", {h_up, h_ld, v_up, v_ld});
        end
        @(negedge clk);
        checks++;
        if (hcount !== 16'd0 || vcount !== 16'(VT - 2)) begin
            failures++;
            $display("FAIL line_wrap_counts got=%0d/%0d want=0/%0d", hcount, vcount, VT - 2);
        end
        force_counts(16'(HT - 1), 16'(VT - 1));
        wait_pix(ok);
        checks++;
        if (!ok || {h_up, h_ld, v_up, v_ld} !== 4'b0101) begin
            failures++;
            $display("FAIL frame_wrap_strobes got=%b want=0101", {h_up, h_ld, v_up, v_ld});
        end
        @(negedge clk);
        checks++;
        if ({frame_tick, parked} !== 2'b10 || hcount !== 16'd0 || vcount !== 16'd0) begin
            failures++;
            $display("FAIL frame_wrap_after got=tick%b park%b %0d/%0d want=tick1 park0 0/0",
                     frame_tick, parked, hcount, vcount);
        end
    endtask

    task automatic wait_wrap(output bit ok, output bit early_park);
        ok = 1'b0;
        early_park = 1'b0;
        for (int n = 0; n < 1200; n++) begin
            @(negedge clk);
            if (parked) early_park = 1'b1;
            if (h_ld && v_ld) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_park();
        bit ok, early;
        force_counts(16'd3, 16'd2);
        run = 1'b0;
        repeat (20) @(negedge clk);
        run = 1'b1;
        wait_wrap(ok, early);
        @(negedge clk);
        checks++;
        if (!ok || parked !== 1'b0 || frame_tick !== 1'b1) begin
            failures++;
            $display("FAIL run_restored_no_park got=wrap%b park%b tick%b want=wrap1 park0 tick1",
                     ok, parked, frame_tick);
        end
        force_counts(16'd3, 16'd2);
        run = 1'b0;
        repeat (10) @(negedge clk);
        run = 1'b1;
        repeat (10) @(negedge clk);
        run = 1'b0;
        wait_wrap(ok, early);
        checks++;
        if (!ok || early || hcount !== 16'(HT - 1) || vcount !== 16'(VT - 1)) begin
            failures++;
            $display("FAIL park_wrap_point got=wrap%b early%b %0d/%0d want=wrap1 early0 %0d/%0d",
                     ok, early, hcount, vcount, HT - 1, VT - 1);
        end
        @(negedge clk);
        checks++;
        if ({parked, frame_tick} !== 2'b11) begin
            failures++;
            $display("FAIL park_entry got=park%b tick%b want=park1 tick1", parked, frame_tick);
        end
        ok = 1'b1;
        repeat (12) begin
            @(negedge clk);
            if ({h_up, h_ld, v_up, v_ld} !== 4'b0000 || hcount !== 16'd0 ||
                vcount !== 16'd0 || parked !== 1'b1) ok = 1'b0;
        end
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL park_hold got=strobes%b %0d/%0d park%b want=strobes0000 0/0 park1",
                     {h_up, h_ld, v_up, v_ld}, hcount, vcount, parked);
        end
        checks++;
        if ({hsync, vsync, active} !== 3'b110) begin
            failures++;
            $display("FAIL park_decode got=%b want=110", {hsync, vsync, active});
        end
        run = 1'b1;
        @(negedge clk);
        checks++;
        if (parked !== 1'b0) begin
            failures++;
            $display("FAIL park_exit got=%b want=0", parked);
        end
        wait_pix(ok);
        checks++;
        if (!ok || {h_up, h_ld, v_up, v_ld} !== 4'b1000) begin
            failures++;
            $display("FAIL resume_strobe got=%b want=1000", {h_up, h_ld, v_up, v_ld});
        end
        @(negedge clk);
        checks++;
        if (hcount !== 16'd1 || vcount !== 16'd0) begin
            failures++;
            $display("FAIL resume_counts got=%0d/%0d want=1/0", hcount, vcount);
        end
    endtask

    task automatic test_resync();
        bit ok;
        int pulses;
        force_counts(16'd5, 16'd600);
        checks++;
        if ({h_up, v_up, resync} !== 3'b000) begin
            failures++;
            $display("FAIL oor_cycle got=hup%b vup%b resync%b want=000", h_up, v_up, resync);
        end
        @(negedge clk);
        checks++;
        if ({resync, h_ld, v_ld, h_up, v_up} !== 5'b11100) begin
            failures++;
            $display("FAIL resync_init got=%b want=11100", {resync, h_ld, v_ld, h_up, v_up});
        end
        @(negedge clk);
        checks++;
        if (hcount !== 16'd0 || vcount !== 16'd0) begin
            failures++;
            $display("FAIL resync_counts got=%0d/%0d want=0/0", hcount, vcount);
        end
        pulses = 0;
        if (resync) pulses++;
        wait_pix(ok);
        checks++;
        if (!ok || h_up !== 1'b1) begin
            failures++;
            $display("FAIL resync_resume got=%b want=1", h_up);
        end
        repeat (20) begin
            @(negedge clk);
            if (resync) pulses++;
        end
        checks++;
        if (pulses != 0) begin
            failures++;
            $display("FAIL resync_single got=%0d extra want=0", pulses);
        end
    endtask

    task automatic test_reset_mid();
        bit tick_seen;
        force_counts(16'd5, 16'd3);
        repeat (2) @(negedge clk);
        checks++;
        if (active !== 1'b1) begin
            failures++;
            $display("FAIL mid_active got=%b want=1", active);
        end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({h_up, h_ld, v_up, v_ld, hsync, vsync, active, frame_tick, parked, resync}
            !== 10'b0000110000) begin
            failures++;
            $display("FAIL mid_reset_outputs got=%b want=0000110000",
                     {h_up, h_ld, v_up, v_ld, hsync, vsync, active, frame_tick, parked, resync});
        end
        tick_seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (frame_tick) tick_seen = 1'b1;
        end
        checks++;
        if (hcount !== 16'd5 || vcount !== 16'd3) begin
            failures++;
            $display("FAIL mid_reset_hold got=%0d/%0d want=5/3", hcount, vcount);
        end
        reset = 1'b0;
        #1;
        checks++;
        if ({h_up, h_ld, v_up, v_ld} !== 4'b0101) begin
            failures++;
            $display("FAIL mid_reset_init got=%b want=0101", {h_up, h_ld, v_up, v_ld});
        end
        repeat (100) begin
            @(negedge clk);
            if (frame_tick) tick_seen = 1'b1;
        end
        checks++;
        if (tick_seen) begin
            failures++;
            $display("FAIL mid_reset_no_tick got=tick want=none");
        end
    endtask

    initial begin
        test_reset();
        test_frame();
        test_line_wrap();
        test_park();
        test_resync();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vga_scan_controller.md
# vga_scan_controller

Sequencer for the VGA raster counters on the Basys 3. It issues the count-up and load strobes to the horizontal and vertical up/down counters at pixel rate and wraps them at end of line and end of frame. It also decodes registered hsync, vsync and active-video from the counts. It can park the raster at a frame boundary on request, and it self-resynchronises if the counters ever leave the legal range.

## Interface

Parameters (defaults give 640x480 @ 60 Hz):
- H_ACTIVE, 640, visible columns
- H_FP, 16, horizontal front porch
- H_SYNC, 96, hsync width
- H_TOTAL, 800, columns per line
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch
- V_SYNC, 2, vsync width
- V_TOTAL, 525, lines per frame

Ports:
- clk  in  1  system clock, 100 MHz
- reset  in  1  synchronous, active-high; one clock, and reset is synchronous and active-high
- pix_en  in  1  pixel-rate enable, high 1 of every 4 clk cycles
- hcount  in  16  current horizontal counter value
- vcount  in  16  current vertical counter value
- run  in  1  level; high means scan, low means park at next frame end
- h_up  out  1  horizontal counter count-up strobe
- h_ld  out  1  horizontal counter load strobe; the counter's D input is tied to 0
- v_up  out  1  vertical counter count-up strobe
- v_ld  out  1  vertical counter load strobe; the counter's D input is tied to 0
- hsync  out  1  active-low horizontal sync, registered
- vsync  out  1  active-low vertical sync, registered
- active  out  1  high inside the visible region, registered
- frame_tick  out  1  one-clk pulse after each frame wrap
- parked  out  1  high while in PARK
- resync  out  1  one-clk pulse when an out-of-range count forces INIT

## Operation

FSM states: INIT, RUN, PARK. Reset enters INIT.

Strobes are decoded combinationally from state, pix_en and the counts. At most one of h_up/h_ld and at most one of v_up/v_ld is high in any cycle.

- INIT: h_ld=v_ld=1 for exactly one clk, independent of pix_en. The next state is RUN.
- RUN, pix_en=0: no strobes.
- RUN, pix_en=1, hcount != H_TOTAL-1: h_up=1.
- RUN, pix_en=1, hcount == H_TOTAL-1, vcount != V_TOTAL-1: h_ld=1, v_up=1.
- RUN, pix_en=1, hcount == H_TOTAL-1, vcount == V_TOTAL-1 (frame wrap): h_ld=1, v_ld=1. The next clk has frame_tick=1. If run=0 in the wrap cycle, the next state is PARK; otherwise the FSM stays in RUN.
- RUN, hcount >= H_TOTAL or vcount >= V_TOTAL (checked every clk, with priority over all other RUN rules): no up strobes. The next state is INIT and resync=1 for one clk.
- PARK: no strobes and parked=1. When run=1, the next state is RUN, and counting resumes at the first pix_en after entry.
- run dropping mid-frame has no effect until that frame's wrap. run toggling within a frame is ignored except for its value in the wrap cycle.

Decode, registered every clk (not gated by pix_en), from the current hcount/vcount, with full 16-bit unsigned compares:
- hsync=0 iff H_ACTIVE+H_FP <= hcount <= H_ACTIVE+H_FP+H_SYNC-1 (656..751).
- vsync=0 iff V_ACTIVE+V_FP <= vcount <= V_ACTIVE+V_FP+V_SYNC-1 (490..491).
- active=1 iff hcount < H_ACTIVE and vcount < V_ACTIVE.
- In PARK and INIT, the registered values are forced: hsync=1, vsync=1, active=0.

Reset values: state=INIT, hsync=1, vsync=1, active=0, frame_tick=0, parked=0, resync=0. All strobes are 0 during the reset cycle, because reset dominates.

## Timing

- The strobe-to-counter path is combinational; the counters update on the same clk edge as the strobe.
- hsync, vsync and active lag the counts by exactly 1 clk.
- frame_tick is high in the clk immediately after the wrap strobe cycle.
- parked rises 1 clk after the wrap cycle that sampled run=0. It falls 1 clk after run=1 is sampled in PARK.
- After reset deasserts: INIT (strobes) in cycle 1, RUN from cycle 2.
- Steady-state frame period: 800 x 525 pix_en pulses, i.e. 1,680,000 clk at a 1-in-4 enable.
- Reset asserted mid-frame returns to INIT on the next edge. No frame_tick is generated for the aborted frame.

## Test plan

- Reset release with counters at arbitrary values (hcount=300, vcount=100) -> one cycle with h_ld=v_ld=1; counts read 0/0; hsync=vsync=1 and active=0 throughout.
- Run one full frame with run=1 -> 800x525 pix_en pulses per frame; exactly 1 frame_tick per frame. hsync low for 96 pixels starting at hcount=656. vsync low on lines 490–491. active high for 640x480 pixels per frame.
- hcount=799 and vcount=523 with pix_en -> h_ld=1 and v_up=1 in the same clk; next counts 0/524.
- Drop run at vcount=200 -> scanning continues until the wrap at 799/524. parked=1 the next clk; the counts hold 0/0 with no strobes. Raise run -> counting resumes at the next pix_en.
- Force vcount=600 in RUN -> resync pulses once, the FSM passes through INIT (h_ld=v_ld=1), and normal scanning resumes from 0/0.
- Assert reset at hcount=400/vcount=300 -> outputs return to reset values on the next edge; no frame_tick is produced.
